fp_to_int: RTL

FP_TO_INT -- requirements
Module: fp_to_int

---
 rtl/fp_to_int.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_to_int.sv
// fp_to_int: 3-stage IEEE-754 single -> 32-bit fixed-point (Q FRAC_BITS) converter with rounding/saturation.
// Define FP_TO_INT_FLAGS_EN to add the Flags output {Invalid, Overflow, Inexact}.
module fp_to_int #(
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data_In,
  input  logic        Valid_In,
  output logic        Ready_Out,
  input  logic [1:0]  RMode,
  input  logic        Signed_Mode,
  output logic [31:0] Data_Out,
  output logic        Valid_Out,
  input  logic        Ready_In
`ifdef FP_TO_INT_FLAGS_EN
  ,
  output logic [2:0]  Flags
`endif
);

  localparam int unsigned W_DATA  = 32;
  localparam int unsigned W_MAG   = W_DATA + 1;
  localparam int unsigned W_MANT  = 24;
  localparam int unsigned W_EXT   = 64;
  localparam int unsigned W_AMT   = 5;
  localparam int unsigned W_K     = 11;
  localparam int unsigned MAX_RSH = 26;
  localparam int unsigned MAX_LSH = 8;
  localparam int unsigned EXP_OFS = 150;

  localparam logic [W_DATA-1:0] SMAX    = 32'h7FFF_FFFF;
  localparam logic [W_DATA-1:0] SMIN    = 32'h8000_0000;
  localparam logic [W_DATA-1:0] UMAX    = 32'hFFFF_FFFF;
  localparam logic [W_MAG-1:0]  POS_LIM = 33'h0_7FFF_FFFF;
  localparam logic [W_MAG-1:0]  NEG_LIM = 33'h0_8000_0000;

  // Whole pipeline advances unless a result is being held at the output
  logic advance_c;
  assign advance_c = ~(Valid_Out & ~Ready_In);
  assign Ready_Out = advance_c;

  // ---------------- S1: unpack / classify / shift plan ----------------
  logic [7:0]             exp_c;
  logic [22:0]            frac_c;
  logic signed [W_K-1:0]  k_c;
  logic signed [W_K-1:0]  nk_c;
  logic                   s1_sign_d, s1_nan_d, s1_inf_d, s1_huge_d, s1_left_d;
  logic [W_AMT-1:0]       s1_amt_d;
  logic [W_MANT-1:0]      s1_mant_d;

  logic                   s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_huge_q, s1_left_q;
  logic [W_AMT-1:0]       s1_amt_q;
  logic [W_MANT-1:0]      s1_mant_q;
  logic [1:0]             s1_rmode_q;
  logic                   s1_signed_q;

  always_comb begin
    exp_c     = Data_In[30:23];
    frac_c    = Data_In[22:0];
    // value = mant24 * 2^k; k > 8 can never fit in 32 integer bits
    k_c       = $signed({3'b000, exp_c}) - $signed(W_K'(EXP_OFS)) + $signed(W_K'(FRAC_BITS));
    nk_c      = -k_c;
    s1_sign_d = Data_In[31];
    s1_nan_d  = (exp_c == 8'hFF) && (frac_c != '0);
    s1_inf_d  = (exp_c == 8'hFF) && (frac_c == '0);
    s1_huge_d = 1'b0;
    s1_left_d = 1'b0;
    s1_amt_d  = W_AMT'(MAX_RSH);
    s1_mant_d = {(exp_c != 8'h00), frac_c};
    if (exp_c != 8'h00) begin
      if (k_c > $signed(W_K'(MAX_LSH))) begin
        s1_huge_d = 1'b1;
        s1_left_d = 1'b1;
        s1_amt_d  = '0;
      end else if (k_c >= $signed(W_K'(0))) begin
        s1_left_d = 1'b1;
        s1_amt_d  = W_AMT'(k_c);
      end else if (nk_c < $signed(W_K'(MAX_RSH))) begin
        s1_amt_d  = W_AMT'(nk_c);
      end
    end
  end

  // ---------------- S2: align shift into 32.32 fixed point ----------------
  logic [W_EXT-1:0]  shifted_c;
  logic [W_DATA-1:0] s2_int_d;
  logic              s2_g_d, s2_r_d, s2_s_d;

  logic              s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_huge_q;
  logic [W_DATA-1:0] s2_int_q;
  logic              s2_g_q, s2_r_q, s2_s_q;
  logic [1:0]        s2_rmode_q;
  logic              s2_signed_q;

  always_comb begin
    shifted_c = {8'h00, s1_mant_q, 32'h0000_0000};
    if (s1_left_q) begin
      shifted_c = shifted_c << s1_amt_q;
    end else begin
      shifted_c = shifted_c >> s1_amt_q;
    end
    s2_int_d = shifted_c[63:32];
    s2_g_d   = shifted_c[31];
    s2_r_d   = shifted_c[30];
    s2_s_d   = |shifted_c[29:0];
  end

  // ---------------- S3: round / saturate ----------------
  logic              inexact_c, inc_c, ovr_c;
  logic [W_MAG-1:0]  mag_c;
  logic [W_DATA-1:0] data_d;
  logic              valid_q;
  logic [W_DATA-1:0] data_q;

  always_comb begin
    inexact_c = s2_g_q | s2_r_q | s2_s_q;
    inc_c     = 1'b0;
    case (s2_rmode_q)
      2'b00:   inc_c = s2_g_q & (s2_r_q | s2_s_q | s2_int_q[0]);
      2'b01:   inc_c = s2_sign_q & inexact_c;
      2'b10:   inc_c = ~s2_sign_q & inexact_c;
      default: inc_c = 1'b0;
    endcase
    mag_c  = {1'b0, s2_int_q} + W_MAG'(inc_c);
    ovr_c  = s2_huge_q | s2_inf_q;
    data_d = '0;
    if (s2_nan_q) begin
      data_d = s2_signed_q ? SMAX : UMAX;
    end else if (s2_signed_q) begin
      if (s2_sign_q) begin
        data_d = (ovr_c || (mag_c > NEG_LIM)) ? SMIN : (32'd0 - mag_c[W_DATA-1:0]);
      end else begin
        data_d = (ovr_c || (mag_c > POS_LIM)) ? SMAX : mag_c[W_DATA-1:0];
      end
    end else if (!s2_sign_q) begin
      data_d = (ovr_c || mag_c[W_DATA]) ? UMAX : mag_c[W_DATA-1:0];
    end
  end

  // Pipeline registers; payloads load only with valid data
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_huge_q   <= 1'b0;
      s1_left_q   <= 1'b0;
      s1_amt_q    <= '0;
      s1_mant_q   <= '0;
      s1_rmode_q  <= '0;
      s1_signed_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_huge_q   <= 1'b0;
      s2_int_q    <= '0;
      s2_g_q      <= 1'b0;
      s2_r_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_rmode_q  <= '0;
      s2_signed_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else if (advance_c) begin
      s1_valid_q <= Valid_In;
      s2_valid_q <= s1_valid_q;
      valid_q    <= s2_valid_q;
      if (Valid_In) begin
        s1_sign_q   <= s1_sign_d;
        s1_nan_q    <= s1_nan_d;
        s1_inf_q    <= s1_inf_d;
        s1_huge_q   <= s1_huge_d;
        s1_left_q   <= s1_left_d;
        s1_amt_q    <= s1_amt_d;
        s1_mant_q   <= s1_mant_d;
        s1_rmode_q  <= RMode;
        s1_signed_q <= Signed_Mode;
      end
      if (s1_valid_q) begin
        s2_sign_q   <= s1_sign_q;
        s2_nan_q    <= s1_nan_q;
        s2_inf_q    <= s1_inf_q;
        s2_huge_q   <= s1_huge_q;
        s2_int_q    <= s2_int_d;
        s2_g_q      <= s2_g_d;
        s2_r_q      <= s2_r_d;
        s2_s_q      <= s2_s_d;
        s2_rmode_q  <= s1_rmode_q;
        s2_signed_q <= s1_signed_q;
      end
      if (s2_valid_q) begin
        data_q <= data_d;
      end
    end
  end

  assign Valid_Out = valid_q;
  assign Data_Out  = data_q;

`ifdef FP_TO_INT_FLAGS_EN
  logic [2:0] flags_d;
  logic [2:0] flags_q;

  // {Invalid, Overflow, Inexact}, aligned with data_d
  always_comb begin
    flags_d = {2'b00, inexact_c};
    if (s2_nan_q) begin
      flags_d = 3'b100;
    end else if (s2_inf_q) begin
      flags_d = 3'b010;
    end else if (!s2_signed_q && s2_sign_q) begin
      flags_d[2] = s2_huge_q | (mag_c != '0);
    end else if (s2_signed_q && s2_sign_q) begin
      flags_d[1] = s2_huge_q | (mag_c > NEG_LIM);
    end else if (s2_signed_q) begin
      flags_d[1] = s2_huge_q | (mag_c > POS_LIM);
    end else begin
      flags_d[1] = s2_huge_q | mag_c[W_DATA];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flags_q <= '0;
    end else if (advance_c && s2_valid_q) begin
      flags_q <= flags_d;
    end
  end

  assign Flags = flags_q;
`endif

endmodule
